// File: rtl/act_lut_writeback.sv
// act_lut_writeback: shared-LUT activation lookup with wrapping output write-back.
// Define ACT_PACK_EN to pack two lane results per output word.
module act_lut_writeback #(
    parameter int LANES  = 4,
    parameter int DW     = 16,
    parameter int LUT_AW = 12,
    parameter int OUT_AW = 13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [OUT_AW-1:0]         cfg_base,
    input  logic [OUT_AW-1:0]         cfg_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*LUT_AW-1:0]   in_addr,
    input  logic [LANES-1:0]          in_sign,
    output logic                      lut_ren,
    output logic [LUT_AW-1:0]         lut_raddr,
    input  logic [2*DW-1:0]           lut_rdata,
    output logic                      out_we,
    output logic [OUT_AW-1:0]         out_waddr,
    output logic [2*DW-1:0]           out_wdata,
    output logic                      busy,
    output logic                      done
);
`ifdef ACT_PACK_EN
    localparam int W = LANES / 2;
`else
    localparam int W = LANES;
`endif
    localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
    localparam int WW = W > 1 ? $clog2(W) : 1;
    localparam logic [IW-1:0] R_LAST = IW'(LANES - 1);
    localparam logic [WW-1:0] W_LAST = WW'(W - 1);

    typedef enum logic [1:0] {IDLE, RD, DRAIN, WR} state_t;

    state_t            state;
    logic [IW-1:0]     r;
    logic [IW-1:0]     cap;
    logic [WW-1:0]     w;
    logic [WW-1:0]     wsel;
    logic [OUT_AW-1:0] base;
    logic [OUT_AW-1:0] len;
    logic [OUT_AW-1:0] wcnt;
    logic [OUT_AW-1:0] wcnt_inc;
    logic              wrap;
    logic              wr_nx;
    logic [LUT_AW-1:0] addr_q [LANES];
    logic [LANES-1:0]  sign_q;
    logic [DW-1:0]     res    [LANES];
    logic [DW-1:0]     res_nx [LANES];
    logic [DW-1:0]     cur;
    logic [2*DW-1:0]   word;

    // Lane whose LUT word is on lut_rdata this cycle (one behind the read index).
    assign cap      = (state == DRAIN) ? R_LAST : r - 1'b1;
    assign cur      = sign_q[cap] ? lut_rdata[2*DW-1:DW] : lut_rdata[DW-1:0];
    assign wcnt_inc = wcnt + OUT_AW'(1);
    // len==0 naturally means 2^OUT_AW because wcnt_inc wraps to zero.
    assign wrap     = wcnt_inc == len;
    assign wr_nx    = state == DRAIN || (state == WR && w != W_LAST);
    assign wsel     = (state == WR && w != W_LAST) ? w + 1'b1 : '0;

`ifdef ACT_PACK_EN
    assign word = {res_nx[{wsel, 1'b1}], res_nx[{wsel, 1'b0}]};
`else
    assign word = {{DW{1'b0}}, res_nx[wsel]};
`endif

    // Result array with this cycle's capture folded in, so a word can use a lane captured on the same edge.
    always_comb begin
        res_nx = res;
        if (state == DRAIN || (state == RD && r != '0)) res_nx[cap] = cur;
    end

    // Control FSM with registered outputs and write-address counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            r         <= '0;
            w         <= '0;
            base      <= '0;
            len       <= '0;
            wcnt      <= '0;
            addr_q    <= '{default: '0};
            sign_q    <= '0;
            res       <= '{default: '0};
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            lut_ren   <= 1'b0;
            lut_raddr <= '0;
            out_we    <= 1'b0;
            out_waddr <= '0;
            out_wdata <= '0;
            done      <= 1'b0;
        end else begin
            res <= res_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        base <= cfg_base;
                        len  <= cfg_len;
                        wcnt <= '0;
                    end else if (in_valid) begin
                        for (int k = 0; k < LANES; k++) addr_q[k] <= in_addr[k*LUT_AW +: LUT_AW];
                        sign_q    <= in_sign;
                        r         <= '0;
                        state     <= RD;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        lut_ren   <= 1'b1;
                        lut_raddr <= in_addr[LUT_AW-1:0];
                    end
                end
                RD: begin
                    if (r == R_LAST) begin
                        state   <= DRAIN;
                        lut_ren <= 1'b0;
                    end else begin
                        r         <= r + 1'b1;
                        lut_raddr <= addr_q[r + 1'b1];
                    end
                end
                DRAIN: state <= WR;
                WR: begin
                    if (w == W_LAST) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            out_we <= wr_nx;
            done   <= wr_nx && wrap;
            if (wr_nx) begin
                w         <= wsel;
                out_waddr <= base + wcnt;
                out_wdata <= word;
                wcnt      <= wrap ? '0 : wcnt_inc;
            end
        end
    end
endmodule

// File: tb/tb_act_lut_writeback.sv
// tb_act_lut_writeback: directed bench with a transaction-level model of act_lut_writeback.
module tb_act_lut_writeback;
    localparam int LANES  = 4;
    localparam int DW     = 16;
    localparam int LUT_AW = 12;
    localparam int OUT_AW = 13;
`ifdef ACT_PACK_EN
    localparam int W = LANES / 2;
`else
    localparam int W = LANES;
`endif
    localparam int PERIOD = LANES + W + 2;
    localparam int ASPACE = 1 << OUT_AW;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    start = 1'b0;
    logic [OUT_AW-1:0]       cfg_base = '0;
    logic [OUT_AW-1:0]       cfg_len = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [LANES*LUT_AW-1:0] in_addr = '0;
    logic [LANES-1:0]        in_sign = '0;
    logic                    lut_ren;
    logic [LUT_AW-1:0]       lut_raddr;
    logic [2*DW-1:0]         lut_rdata = '0;
    logic                    out_we;
    logic [OUT_AW-1:0]       out_waddr;
    logic [2*DW-1:0]         out_wdata;
    logic                    busy;
    logic                    done;

    act_lut_writeback #(.LANES(LANES), .DW(DW), .LUT_AW(LUT_AW), .OUT_AW(OUT_AW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_sign(in_sign),
        .lut_ren(lut_ren), .lut_raddr(lut_raddr), .lut_rdata(lut_rdata),
        .out_we(out_we), .out_waddr(out_waddr), .out_wdata(out_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] lut_fn(input logic [11:0] a);
        return (a == 12'h010) ? 32'hBEEF_1234 : {4'hA, a, 4'h5, ~a};
    endfunction

    // LUT SRAM: one-cycle read latency, junk when not read.
    always @(posedge clk) lut_rdata <= lut_ren ? lut_fn(lut_raddr) : 32'h5A5A_A5A5;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int          cyc;
        logic [12:0] a;
        logic [31:0] d;
        logic        dn;
    } wr_t;

    // Model state: config, write counter, current group timing and expected writes.
    bit          active = 0;
    int          k = 0;
    int          mbase = 0;
    int          mlen = 0;
    int          mwcnt = 0;
    int          acc_cnt = 0;
    int          acc_q[$];
    logic [11:0] m_addr [LANES];
    wr_t         exp_q[$];
    wr_t         log_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            active = 0; k = 0; mbase = 0; mlen = 0; mwcnt = 0;
            exp_q.delete();
        end else if (!active) begin
            if (start) begin
                mbase = cfg_base; mlen = cfg_len; mwcnt = 0;
            end else if (in_valid) begin
                logic [15:0] res [LANES];
                int eff;
                wr_t e;
                active = 1; k = 0; acc_cnt++;
                acc_q.push_back(edge_cnt + 1);
                for (int i = 0; i < LANES; i++) begin
                    logic [31:0] wd;
                    m_addr[i] = in_addr[i*LUT_AW +: LUT_AW];
                    wd = lut_fn(m_addr[i]);
                    res[i] = in_sign[i] ? wd[31:16] : wd[15:0];
                end
                eff = (mlen == 0) ? ASPACE : mlen;
                for (int i = 0; i < W; i++) begin
                    e.cyc = 0;
                    e.a = 13'((mbase + mwcnt) % ASPACE);
`ifdef ACT_PACK_EN
                    e.d = {res[2*i+1], res[2*i]};
`else
                    e.d = {16'h0, res[i]};
`endif
                    e.dn = (mwcnt + 1 == eff);
                    mwcnt = e.dn ? 0 : mwcnt + 1;
                    exp_q.push_back(e);
                end
            end
        end else begin
            k++;
            if (k == LANES + W + 1) active = 0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit exp_ren, exp_we;
        wr_t e, g;
        exp_ren = active && k < LANES;
        exp_we  = active && k >= LANES + 1 && k <= LANES + W;
        chk("in_ready", in_ready, !active);
        chk("busy", busy, active);
        chk("lut_ren", lut_ren, exp_ren);
        if (exp_ren) chk("lut_raddr", lut_raddr, m_addr[k]);
        chk("out_we", out_we, exp_we);
        if (exp_we && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_waddr", out_waddr, e.a);
            chk("out_wdata", out_wdata, e.d);
            chk("done", done, e.dn);
        end else begin
            chk("done_idle", done, 1'b0);
        end
        if (rst) begin
            chk("rst_raddr", lut_raddr, 0);
            chk("rst_waddr", out_waddr, 0);
            chk("rst_wdata", out_wdata, 0);
        end
        if (out_we) begin
            g.cyc = edge_cnt + 1; g.a = out_waddr; g.d = out_wdata; g.dn = done;
            log_q.push_back(g);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [12:0] b, input logic [12:0] l);
        start = 1'b1; cfg_base = b; cfg_len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [LANES*LUT_AW-1:0] a, input logic [LANES-1:0] s, output int t);
        int c0, n;
        c0 = acc_cnt; n = 0;
        in_addr = a; in_sign = s; in_valid = 1'b1;
        while (acc_cnt == c0 && n < 60) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        in_addr = ~a;
        in_sign = ~s;
        chk("accept", acc_cnt - c0, 1);
        t = acc_q.size() > 0 ? acc_q[$] : 0;
    endtask

    task automatic wait_idle(input int t);
        int n;
        n = 0;
        while (!in_ready && n < 60) begin
            tick();
            n++;
        end
        chk("ready_ret", edge_cnt + 1 - t, PERIOD);
    endtask

    localparam logic [LANES*LUT_AW-1:0] G_SIGN = {4{12'h010}};
    localparam logic [LANES*LUT_AW-1:0] G_A    = {12'hFFF, 12'h010, 12'h456, 12'h123};
    localparam logic [LANES*LUT_AW-1:0] G_B    = {12'h001, 12'h800, 12'h010, 12'h7A7};

    initial begin
        int t, t2, c0, n, s_e;
        logic [31:0] exp_sign [W];
        logic [12:0] exp_wa [2*W];
        int done_idx;
`ifdef ACT_PACK_EN
        exp_sign = '{32'hBEEF_1234, 32'hBEEF_1234};
        exp_wa   = '{13'h200, 13'h201, 13'h202, 13'h200};
        done_idx = 2;
`else
        exp_sign = '{32'h0000_1234, 32'h0000_BEEF, 32'h0000_1234, 32'h0000_BEEF};
        exp_wa   = '{13'h200, 13'h201, 13'h202, 13'h203, 13'h204, 13'h205, 13'h200, 13'h201};
        done_idx = 5;
`endif
        #1 rst = 1'b1;
        repeat (3) tick();
        chk("reset_ready", in_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;
        tick();

        // Sign select; inputs are scrambled after acceptance and must not matter.
        cfg(13'h100, 13'h0);
        log_q.delete();
        send(G_SIGN, 4'b1010, t);
        wait_idle(t);
        chk("sign_n", log_q.size(), W);
        for (int i = 0; i < W && i < log_q.size(); i++) begin
            chk("sign_addr", log_q[i].a, 13'(13'h100 + i));
            chk("sign_data", log_q[i].d, exp_sign[i]);
            chk("sign_cyc", log_q[i].cyc - t, 6 + i);
        end

        // Wrap and done, with an ignored start between the groups.
`ifdef ACT_PACK_EN
        cfg(13'h200, 13'd3);
`else
        cfg(13'h200, 13'd6);
`endif
        log_q.delete();
        send(G_A, 4'b0110, t);
        start = 1'b1; cfg_base = 13'h1555; cfg_len = 13'd1;
        tick();
        start = 1'b0;
        send(G_B, 4'b1001, t2);
        wait_idle(t2);
        chk("wrap_n", log_q.size(), 2 * W);
        for (int i = 0; i < 2 * W && i < log_q.size(); i++) begin
            chk("wrap_addr", log_q[i].a, exp_wa[i]);
            chk("wrap_done", log_q[i].dn, i == done_idx);
        end

        // Simultaneous start and in_valid: config wins, group accepted next cycle.
        log_q.delete();
        start = 1'b1; cfg_base = 13'h040; cfg_len = 13'h0;
        in_valid = 1'b1; in_addr = G_A; in_sign = 4'b0011;
        c0 = acc_cnt;
        s_e = edge_cnt + 1;
        tick();
        start = 1'b0;
        chk("sim_noacc", acc_cnt - c0, 0);
        chk("sim_ren", lut_ren, 1'b0);
        n = 0;
        while (acc_cnt == c0 && n < 60) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("sim_acc", acc_cnt - c0, 1);
        t = acc_q.size() > 0 ? acc_q[$] : 0;
        chk("sim_delay", t - s_e, 1);
        wait_idle(t);
        chk("sim_base", log_q.size() > 0 ? log_q[0].a : 13'h1FFF, 13'h040);

        // Back-pressure: in_valid held for three groups.
        c0 = acc_cnt;
        in_valid = 1'b1; in_addr = G_B; in_sign = 4'b0101;
        n = 0;
        while (acc_cnt < c0 + 3 && n < 100) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("bp_n", acc_cnt - c0, 3);
        if (acc_q.size() >= 3) begin
            chk("bp_gap1", acc_q[$] - acc_q[$-1], PERIOD);
            chk("bp_gap2", acc_q[$-1] - acc_q[$-2], PERIOD);
        end
        wait_idle(acc_q[$]);

        // Reset mid-RD: partial group dropped, config lost, next group starts at 0.
        cfg(13'h300, 13'd2);
        send(G_A, 4'b1111, t);
        tick();
        chk("mid_rd_ren", lut_ren, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_we", out_we, 1'b0);
        rst = 1'b0;
        tick();
        log_q.delete();
        send(G_B, 4'b0000, t);
        wait_idle(t);
        chk("rst_n", log_q.size(), W);
        for (int i = 0; i < W && i < log_q.size(); i++) begin
            chk("rst_addr", log_q[i].a, 13'(i));
            chk("rst_nodone", log_q[i].dn, 1'b0);
        end
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
